seg7_scan_mux: RTL and testbench

SEG7_SCAN_MUX -- requirements
Module: seg7_scan_mux

---
 rtl/seg7_scan_mux.sv | 94 +++++++++
 tb/tb_seg7_scan_mux.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/seg7_scan_mux.sv
// Time-multiplexed 7-segment driver: one digit per slot, a blanking lead-in per slot,
// and PWM brightness inside the ON window using values snapshotted when the window opens.
module seg7_scan_mux #(
  parameter int NUM_7SEGMENTS = 8,
  parameter int DEAD_CYCLES   = 16,
  parameter int BRIGHT_WIDTH  = 8,
  parameter int PRESCALE      = 64
) (
  input  logic                     clk,
  input  logic                     n_rst,
  input  logic [6:0]               i_hex [0:NUM_7SEGMENTS-1],
  input  logic [NUM_7SEGMENTS-1:0] i_digit_en,
  input  logic [BRIGHT_WIDTH-1:0]  i_brightness,
  output logic [6:0]               o_seg,
  output logic [NUM_7SEGMENTS-1:0] o_an,
  output logic                     o_frame_start
);

  localparam int SLOT   = DEAD_CYCLES + (1 << BRIGHT_WIDTH);
  localparam int TICK_W = $clog2(SLOT);
  localparam int PRE_W  = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int DIG_W  = (NUM_7SEGMENTS > 1) ? $clog2(NUM_7SEGMENTS) : 1;

  localparam logic [TICK_W-1:0] DEAD_T   = TICK_W'(DEAD_CYCLES);
  localparam logic [TICK_W-1:0] LAST_T   = TICK_W'(SLOT - 1);
  localparam logic [PRE_W-1:0]  LAST_PRE = PRE_W'(PRESCALE - 1);
  localparam logic [DIG_W-1:0]  LAST_DIG = DIG_W'(NUM_7SEGMENTS - 1);

  logic [PRE_W-1:0]        pre_cnt;
  logic [TICK_W-1:0]       tick_cnt;
  logic [DIG_W-1:0]        digit;
  logic                    snap_en;
  logic [BRIGHT_WIDTH-1:0] snap_br;
  logic [6:0]              snap_pat;

  logic                    tick_fire;
  logic                    first_on;
  logic                    in_on;
  logic [TICK_W-1:0]       on_idx;
  logic                    cur_en;
  logic [BRIGHT_WIDTH-1:0] cur_br;
  logic [6:0]              cur_pat;
  logic                    lit;
  logic [NUM_7SEGMENTS-1:0] one_hot;

  // tick_cnt/digit name the tick that the next tick edge puts on the outputs; on the
  // first ON tick the live inputs are used so outputs and snapshot agree from the start.
  always_comb begin
    tick_fire = (pre_cnt == '0);
    first_on  = (tick_cnt == DEAD_T);
    in_on     = (tick_cnt >= DEAD_T);
    on_idx    = tick_cnt - DEAD_T;
    cur_en    = first_on ? i_digit_en[digit] : snap_en;
    cur_br    = first_on ? i_brightness      : snap_br;
    cur_pat   = first_on ? i_hex[digit]      : snap_pat;
    lit       = in_on && cur_en &&
                ({{(TICK_W-BRIGHT_WIDTH){1'b0}}, cur_br} > on_idx);
    one_hot   = NUM_7SEGMENTS'(1) << digit;
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      pre_cnt       <= '0;
      tick_cnt      <= '0;
      digit         <= '0;
      snap_en       <= 1'b0;
      snap_br       <= '0;
      snap_pat      <= 7'h7f;
      o_an          <= '1;
      o_seg         <= 7'h7f;
      o_frame_start <= 1'b0;
    end else begin
      pre_cnt       <= (pre_cnt == LAST_PRE) ? '0 : pre_cnt + 1'b1;
      o_frame_start <= tick_fire && (tick_cnt == '0) && (digit == '0);
      if (tick_fire) begin
        if (first_on) begin
          snap_en  <= i_digit_en[digit];
          snap_br  <= i_brightness;
          snap_pat <= i_hex[digit];
        end
        // Segments and anodes switch on the same edge, so a pattern never leaks to another digit.
        o_an  <= lit ? ~one_hot : '1;
        o_seg <= lit ? cur_pat : 7'h7f;
        if (tick_cnt == LAST_T) begin
          tick_cnt <= '0;
          digit    <= (digit == LAST_DIG) ? '0 : digit + 1'b1;
        end else begin
          tick_cnt <= tick_cnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_seg7_scan_mux.sv
// Bench for seg7_scan_mux with 4 digits, 2 dead ticks, 3-bit brightness, prescale 1.
module tb_seg7_scan_mux;
  localparam int N    = 4;
  localparam int DEAD = 2;
  localparam int BW   = 3;
  localparam int PRE  = 1;
  localparam int SLOTC  = DEAD + (1 << BW);
  localparam int FRAMEC = N * SLOTC;

  logic          clk = 1'b0;
  logic          n_rst = 1'b0;
  logic [6:0]    i_hex [0:N-1];
  logic [N-1:0]  i_digit_en;
  logic [BW-1:0] i_brightness;
  logic [6:0]    o_seg;
  logic [N-1:0]  o_an;
  logic          o_frame_start;

  seg7_scan_mux #(
    .NUM_7SEGMENTS(N), .DEAD_CYCLES(DEAD), .BRIGHT_WIDTH(BW), .PRESCALE(PRE)
  ) dut (
    .clk(clk), .n_rst(n_rst), .i_hex(i_hex), .i_digit_en(i_digit_en),
    .i_brightness(i_brightness), .o_seg(o_seg), .o_an(o_an), .o_frame_start(o_frame_start)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [N-1:0]  en;
    logic [BW-1:0] br;
    logic [27:0]   hex;       // digit d at bits [7d+6:7d]
    int            ncyc;
    int            exp_lit_d0;
    int            exp_lit_all;
  } vec_t;

  typedef struct {
    logic [N-1:0] an;
    logic [6:0]   seg;
    logic         fs;
    int           c;
  } exp_t;

  exp_t sbq[$];
  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;
  logic          m_en;
  logic [BW-1:0] m_br;
  logic [6:0]    m_pat;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s (cycle %0d): got %h, expected %h", name, cyc, act, exp);
    end
  endtask

  task automatic model_reset();
    m_en  = 1'b0;
    m_br  = '0;
    m_pat = 7'h7f;
    cyc   = 0;
  endtask

  // Expected outputs for cycle cyc, from the slot/tick position within the frame.
  task automatic push_expected();
    int s, t;
    logic lit;
    logic [N-1:0] one;
    exp_t e;
    s = (cyc % FRAMEC) / SLOTC;
    t = cyc % SLOTC;
    if (t == DEAD) begin
      m_en  = i_digit_en[s];
      m_br  = i_brightness;
      m_pat = i_hex[s];
    end
    lit  = (t >= DEAD) && m_en && ((t - DEAD) < int'(m_br));
    one  = 1;
    e.an  = lit ? ~(one << s) : '1;
    e.seg = lit ? m_pat : 7'h7f;
    e.fs  = ((cyc % FRAMEC) == 0);
    e.c   = cyc;
    sbq.push_back(e);
  endtask

  task automatic step();
    exp_t e;
    push_expected();
    @(posedge clk);
    #1;
    if (sbq.size() == 0) begin
      check("scoreboard_empty", 32'd0, 32'd1);
    end else begin
      e = sbq.pop_front();
      check("o_an", 32'(o_an), 32'(e.an));
      check("o_seg", 32'(o_seg), 32'(e.seg));
      check("o_frame_start", 32'(o_frame_start), 32'(e.fs));
    end
    check("an_at_most_one_low", 32'($countones(~o_an) <= 1), 32'd1);
    cyc++;
  endtask

  task automatic do_reset();
    n_rst = 1'b0;
    @(posedge clk);
    #1;
    check("reset_an", 32'(o_an), 32'hf);
    check("reset_seg", 32'(o_seg), 32'h7f);
    @(posedge clk);
    @(negedge clk);
    n_rst = 1'b1;
    model_reset();
  endtask

  task automatic apply(input logic [N-1:0] en, input logic [BW-1:0] br, input logic [27:0] hex);
    i_digit_en   = en;
    i_brightness = br;
    for (int d = 0; d < N; d++) i_hex[d] = hex[d*7 +: 7];
  endtask

  vec_t tbl [5];

  initial begin
    int cnt0, cnt_all;
    tbl[0] = '{4'hf,    3'd7, {7'h30, 7'h24, 7'h79, 7'h40}, 81, 7, 28};
    tbl[1] = '{4'hf,    3'd0, {7'h30, 7'h24, 7'h79, 7'h40}, 81, 0, 0};
    tbl[2] = '{4'b0101, 3'd3, {7'h30, 7'h24, 7'h79, 7'h40}, 80, 3, 6};
    tbl[3] = '{4'hf,    3'd1, {7'h12, 7'h19, 7'h30, 7'h24}, 40, 1, 4};
    tbl[4] = '{4'b1000, 3'd5, {7'h00, 7'h02, 7'h78, 7'h66}, 40, 0, 5};

    apply(4'h0, 3'd0, 28'h0);

    // Reset held across clocks with random inputs.
    n_rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      for (int d = 0; d < N; d++) i_hex[d] = 7'($urandom);
      i_digit_en   = N'($urandom);
      i_brightness = BW'($urandom);
      @(posedge clk);
      #1;
      check("hold_reset_an", 32'(o_an), 32'hf);
      check("hold_reset_seg", 32'(o_seg), 32'h7f);
      check("hold_reset_fs", 32'(o_frame_start), 32'h0);
    end

    for (int v = 0; v < 5; v++) begin
      apply(tbl[v].en, tbl[v].br, tbl[v].hex);
      do_reset();
      cnt0 = 0;
      cnt_all = 0;
      for (int i = 0; i < tbl[v].ncyc; i++) begin
        step();
        if (i < FRAMEC) begin
          if (o_an != 4'hf) cnt_all++;
          if (o_an == 4'b1110) cnt0++;
        end
      end
      check("lit_cycles_digit0", 32'(cnt0), 32'(tbl[v].exp_lit_d0));
      check("lit_cycles_frame", 32'(cnt_all), 32'(tbl[v].exp_lit_all));
    end

    // Pattern change mid-slot only takes effect at the next snapshot.
    apply(4'hf, 3'd7, {7'h30, 7'h24, 7'h79, 7'h40});
    do_reset();
    for (int i = 0; i < 46; i++) begin
      step();
      if (i == 4) i_hex[0] = 7'h24;
      if (i == 8) check("seg_held_c8", 32'(o_seg), 32'h40);
      if (i == 42) check("seg_new_c42", 32'(o_seg), 32'h24);
    end

    // Asynchronous reset in the middle of an ON window.
    apply(4'hf, 3'd7, {7'h30, 7'h24, 7'h79, 7'h40});
    do_reset();
    for (int i = 0; i < 6; i++) step();
    check("pre_async_an", 32'(o_an), 32'he);
    #2;
    n_rst = 1'b0;
    #1;
    check("async_an", 32'(o_an), 32'hf);
    check("async_seg", 32'(o_seg), 32'h7f);
    check("async_fs", 32'(o_frame_start), 32'h0);
    @(posedge clk);
    @(negedge clk);
    n_rst = 1'b1;
    model_reset();
    for (int i = 0; i < 12; i++) begin
      step();
      if (i == 1) check("restart_blank_c1", 32'(o_an), 32'hf);
      if (i == 2) check("restart_lit_c2", 32'(o_an), 32'he);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
